rr_arbiter16: RTL and testbench



---
 rtl/rr_arbiter16_pkg.sv | 14 +
 rtl/rr_arbiter16_dec.sv | 15 +
 rtl/rr_arbiter16.sv | 127 ++++++++++++
 tb/tb_rr_arbiter16.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter16_pkg.sv
// Shared definitions for the 16-way round-robin arbiter: arbiter state
// encoding, requester count, index width and the default watchdog limit.
package rr_arbiter16_pkg;

  localparam int N_REQ       = 16;
  localparam int IDX_W       = 4;
  localparam int DEF_TIMEOUT = 255;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter16_dec.sv
// 4-to-16 one-hot decoder shared across the codebase.
module rr_arbiter16_dec
  import rr_arbiter16_pkg::*;
(
  input  logic [IDX_W-1:0] i_idx,
  output logic [N_REQ-1:0] o_onehot
);

  // One output bit per index value.
  always_comb begin
    o_onehot        = '0;
    o_onehot[i_idx] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter16.sv
// Round-robin arbiter sharing one resource among 16 requesters.
// Optional watchdog enabled by defining RR_WATCHDOG_EN.
//
// state  | meaning
// S_IDLE | no owner; arbitrate whenever any request is present
// S_BUSY | owner holds the grant until done (or watchdog expiry)
module rr_arbiter16
   import rr_arbiter16_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic [N_REQ-1:0] req,
   input  logic             done,
   output logic             grant_valid,
   output logic             grant_start,
   output logic [IDX_W-1:0] grant_idx,
`ifdef RR_WATCHDOG_EN
   output logic             timeout_err,
`endif
   output logic [N_REQ-1:0] grant_onehot
);

   arb_state_t       r_state;
   logic             r_grant_valid;
   logic             r_grant_start;
   logic [IDX_W-1:0] r_grant_idx;
   logic [IDX_W-1:0] r_last_idx;

   logic             w_any_req;
   logic [IDX_W-1:0] w_winner;
   logic             w_release;
   logic [N_REQ-1:0] w_dec_onehot;

   assign w_any_req = |req;

`ifdef RR_WATCHDOG_EN
   localparam int CNT_W = ($clog2(TIMEOUT + 1) < 8) ? 8 : $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] r_wd_cnt;
   logic             r_timeout_err;
   logic             w_timeout;

   assign w_timeout = (r_state == S_BUSY) && !done &&
                      (r_wd_cnt == CNT_W'(TIMEOUT - 1));
   assign w_release = done | w_timeout;
   assign timeout_err = r_timeout_err;
`else
   assign w_release = done;
`endif

   always_comb begin
      logic             v_found;
      logic [IDX_W-1:0] v_idx;
      v_found  = 1'b0;
      w_winner = r_last_idx;
      for (int k = 1; k <= N_REQ; k++) begin
         v_idx = r_last_idx + k[IDX_W-1:0];
         if (!v_found && req[v_idx]) begin
            v_found  = 1'b1;
            w_winner = v_idx;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_grant_valid <= 1'b0;
         r_grant_start <= 1'b0;
         r_grant_idx   <= '0;
         r_last_idx    <= IDX_W'(N_REQ - 1);
`ifdef RR_WATCHDOG_EN
         r_wd_cnt      <= '0;
         r_timeout_err <= 1'b0;
`endif
      end else begin
         r_grant_start <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_any_req) begin
                  r_grant_idx   <= w_winner;
                  r_last_idx    <= w_winner;
                  r_grant_valid <= 1'b1;
                  r_grant_start <= 1'b1;
                  r_state       <= S_BUSY;
`ifdef RR_WATCHDOG_EN
                  r_wd_cnt      <= '0;
`endif
               end
            end
            S_BUSY: begin
               if (w_release) begin
                  if (w_any_req) begin
                     r_grant_idx   <= w_winner;
                     r_last_idx    <= w_winner;
                     r_grant_start <= 1'b1;
                  end else begin
                     r_grant_valid <= 1'b0;
                     r_state       <= S_IDLE;
                  end
`ifdef RR_WATCHDOG_EN
                  r_wd_cnt <= '0;
                  if (w_timeout) r_timeout_err <= 1'b1;
               end else begin
                  r_wd_cnt <= r_wd_cnt + CNT_W'(1);
`endif
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   rr_arbiter16_dec u_dec (
      .i_idx    (r_grant_idx),
      .o_onehot (w_dec_onehot)
   );

   assign grant_valid  = r_grant_valid;
   assign grant_start  = r_grant_start;
   assign grant_idx    = r_grant_idx;
   assign grant_onehot = w_dec_onehot & {N_REQ{r_grant_valid}};

endmodule

// File: tb/tb_rr_arbiter16.sv
// Self-checking bench for rr_arbiter16: directed scenarios followed by a
// random phase, all compared against a transaction-level reference model.
module tb_rr_arbiter16;

   localparam int TB_TIMEOUT = 10;

   logic        clk;
   logic        reset;
   logic [15:0] req;
   logic        done;
   logic        grant_valid;
   logic        grant_start;
   logic [3:0]  grant_idx;
   logic [15:0] grant_onehot;
`ifdef RR_WATCHDOG_EN
   logic        timeout_err;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   bit m_valid;
   bit m_start;
   int m_idx;
   int m_last;
   bit m_err;
   int m_held;

   rr_arbiter16 #(.TIMEOUT(TB_TIMEOUT)) dut (
      .clk          (clk),
      .reset        (reset),
      .req          (req),
      .done         (done),
      .grant_valid  (grant_valid),
      .grant_start  (grant_start),
      .grant_idx    (grant_idx),
`ifdef RR_WATCHDOG_EN
      .timeout_err  (timeout_err),
`endif
      .grant_onehot (grant_onehot)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input logic [15:0] r, input int last);
      for (int off = 1; off <= 16; off++) begin
         if (r[(last + off) % 16]) return (last + off) % 16;
      end
      return last;
   endfunction

   task automatic model_reset();
      m_valid = 0; m_start = 0; m_idx = 0; m_last = 15; m_err = 0; m_held = 0;
   endtask

   task automatic model_step(input logic [15:0] r, input bit d);
      bit rel;
      rel = d;
`ifdef RR_WATCHDOG_EN
      if (m_valid && !d) begin
         m_held++;
         if (m_held == TB_TIMEOUT) begin
            rel = 1;
            m_err = 1;
         end
      end
`endif
      m_start = 0;
      if (!m_valid || rel) begin
         m_held = 0;
         if (r != 0) begin
            m_idx   = pick(r, m_last);
            m_last  = m_idx;
            m_valid = 1;
            m_start = 1;
         end else begin
            m_valid = 0;
         end
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".valid"},  32'(grant_valid), 32'(m_valid));
      chk({tag, ".start"},  32'(grant_start), 32'(m_start));
      chk({tag, ".idx"},    32'(grant_idx),   32'(m_idx));
      chk({tag, ".onehot"}, 32'(grant_onehot), m_valid ? (32'd1 << m_idx) : 32'd0);
`ifdef RR_WATCHDOG_EN
      chk({tag, ".err"},    32'(timeout_err), 32'(m_err));
`endif
   endtask

   task automatic cycle(input string tag, input logic [15:0] r, input bit d);
      req  = r;
      done = d;
      @(posedge clk);
      model_step(r, d);
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req = '0;
      done = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check_all("reset");
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      req = '0;
      done = 1'b0;
      model_reset();
      do_reset();

      cycle("first", 16'h0001, 0);
      chk("first.idx_const", 32'(grant_idx), 32'd0);
      chk("first.start_const", 32'(grant_start), 32'd1);
      cycle("first_hold", 16'h0001, 0);

      for (int i = 0; i < 17; i++) begin
         cycle("rot", 16'hFFFF, 1);
         chk("rot.idx_const", 32'(grant_idx), 32'((i + 1) % 16));
         chk("rot.nobubble", 32'(grant_start), 32'd1);
      end

      cycle("to14", 16'h4000, 1);
      cycle("wrap15", 16'h8002, 1);
      chk("wrap15.const", 32'(grant_idx), 32'd15);
      cycle("wrap1", 16'h8002, 1);
      chk("wrap1.const", 32'(grant_idx), 32'd1);

      cycle("to3", 16'h0008, 1);
      for (int i = 0; i < 20; i++) cycle("hold", 16'h0100, 0);
      chk("hold.const", 32'(grant_idx), 32'd3);
      cycle("to8", 16'h0100, 1);
      chk("to8.const", 32'(grant_idx), 32'd8);

      cycle("to5", 16'h0020, 1);
      cycle("idle", 16'h0000, 1);
      chk("idle.valid_const", 32'(grant_valid), 32'd0);
      cycle("idle_done", 16'h0000, 1);
      cycle("idle_quiet", 16'h0000, 0);

      cycle("to7", 16'h0080, 0);
      cycle("own7", 16'h0080, 0);
      @(posedge clk);
      model_step(16'h0080, 0);
      #2 reset = 1'b1;
      model_reset();
      #1;
      check_all("async_reset");
      @(negedge clk);
      reset = 1'b0;
      cycle("after_reset7", 16'h0080, 0);
      chk("after_reset7.const", 32'(grant_idx), 32'd7);
      cycle("after_reset8", 16'hFFFF, 1);
      chk("after_reset8.const", 32'(grant_idx), 32'd8);

      for (int i = 0; i < 400; i++) begin
         logic [15:0] r;
         r = 16'($urandom);
         if ($urandom_range(0, 3) == 0) r = r & 16'($urandom);
         if ($urandom_range(0, 7) == 0) r = '0;
         cycle("rand", r, ($urandom_range(0, 9) < 3));
      end

`ifdef RR_WATCHDOG_EN
      do_reset();
      cycle("wd_to2", 16'h0004, 0);
      for (int i = 0; i < TB_TIMEOUT + 3; i++) cycle("wd", 16'h0014, 0);
      chk("wd.err_const", 32'(timeout_err), 32'd1);
      cycle("wd_done", 16'h0000, 1);
      cycle("wd_idle", 16'h0000, 0);
      chk("wd.sticky", 32'(timeout_err), 32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
